pio_sm_sequencer: RTL
=====================

Name: pio_sm_sequencer

Overview:
Execution controller for one PIO state machine; it sequences the program_counter block.
- Drives its pc_en/jump_en/jump inputs from:
  - the integer clock divider,
  - instruction stall/jump/delay results from the decoder,
  - host control (enable, restart, forced jump).
- Sits between the decoder and program_counter. Wrap handling stays inside program_counter.

Parameters:
ADDR_W, 4, instruction memory address width (matches program_counter pc width)
DELAY_W, 5, width of instruction delay field
DIV_W, 16, width of integer clock divider

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset; clears all state while low
sm_en  input  1  state machine enable; when low, all internal state is frozen
sm_restart  input  1  synchronous pulse; clears divider count and pending delay
clkdiv  input  DIV_W  execution divider; 0 and 1 both mean every enabled cycle
instr_stall  input  1  current instruction cannot complete this tick
instr_jump  input  1  current instruction takes a jump on completion
instr_jump_addr  input  ADDR_W  jump target
instr_delay  input  DELAY_W  idle ticks inserted after the instruction completes
force_jump  input  1  host forced jump pulse
force_addr  input  ADDR_W  host forced jump target
pc_en  output  1  advance PC (to program_counter)
jump_en  output  1  load PC with jump (to program_counter)
jump  output  ADDR_W  jump target (to program_counter)
exec_tick  output  1  instruction retired this cycle
delay_active  output  1  FSM in DELAY
stalled  output  1  stall tick consumed

Behaviour:
- Reset (rst=0, async):
  - div_cnt=0, delay_cnt=0, state=EXEC.
  - All outputs 0; jump=0.
- Divider:
  - tick = sm_en & (clkdiv<=1 | div_cnt>=clkdiv-1).
  - On an enabled cycle: div_cnt resets to 0 on tick, else increments.
  - The >= compare means lowering clkdiv below the current count ticks on the next enabled cycle.
- FSM states: EXEC, DELAY. All outputs are combinational from registered state plus current inputs (zero latency); the PC updates on the edge ending the cycle.
- EXEC on tick:
  - instr_stall=1: no pc_en/jump_en, stalled=1, stay in EXEC. Stall overrides jump and delay.
  - Else retire, exec_tick=1:
    - If instr_jump: jump_en=1, jump=instr_jump_addr, pc_en=0.
    - Else pc_en=1.
    - If instr_delay=N>0: state to DELAY, delay_cnt=N.
- DELAY on tick:
  - delay_cnt decrements.
  - When delay_cnt==1 at tick, go to EXEC.
  - Result: exactly N ticks with no PC activity; instr_stall is ignored.
- No tick: nothing changes except div_cnt.
- sm_en=0: div_cnt, delay_cnt and state are held; no pc_en/exec_tick. force_jump still acts.
- force_jump=1 (highest priority, independent of sm_en and tick):
  - jump_en=1, jump=force_addr, pc_en=0, exec_tick=0.
  - Any retiring instruction is discarded and its delay is not applied.
  - State to EXEC, delay_cnt=0.
- sm_restart=1: div_cnt=0, delay_cnt=0, state to EXEC, no PC outputs that cycle.
  - Combined with force_jump, the forced jump still issues.
- pc_en and jump_en are never both 1.
- Reset asserted mid-DELAY aborts the delay immediately.

Decomposition:
- Package pio_pkg holds:
  - ADDR_W/DELAY_W/DIV_W defaults,
  - the state enum {EXEC, DELAY}.
- Sub-module pio_clk_div (div_cnt and tick generation; inputs clk, rst, en, clear, clkdiv) is natural and is reused per state machine.
- The FSM remains in pio_sm_sequencer.

Test Plan:
- Reset low mid-run -> all outputs 0 asynchronously. After release with sm_en=1, clkdiv=1, no stall/jump/delay: pc_en=1 every cycle.
- clkdiv=3, sm_en=1 -> pc_en pulses on enabled cycles 3, 6, 9. Change clkdiv to 1 when div_cnt=2 -> pulse on the next cycle.
- clkdiv=1, instr_delay=2 retired at cycle 0 -> pc_en at cycle 0; delay_active in cycles 1–2; next pc_en at cycle 3. Drop sm_en during cycle 1 for 4 cycles -> delay resumes and the gap is preserved.
- clkdiv=1, instr_stall=1 for 3 cycles with instr_jump=1, addr=9 -> stalled=1 and no jump_en for 3 cycles. Then jump_en=1, jump=9, exec_tick=1.
- force_jump with force_addr=5 during DELAY and during a retiring jump to 9 -> jump_en=1, jump=5, exec_tick=0, state EXEC. Also with sm_en=0 -> jump_en=1.
- sm_restart during DELAY with div_cnt=1 -> next cycle EXEC, delay_cnt=0, div_cnt=0, no pc_en in the restart cycle.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO state-machine sequencer slice.
// Contents:
//   PIO_ADDR_W / PIO_DELAY_W / PIO_DIV_W - default widths of the instruction
//                                          address, delay field and divider.
//   sm_state_e                           - sequencer FSM state encoding.
package pio_pkg;

  localparam int PIO_ADDR_W  = 4;
  localparam int PIO_DELAY_W = 5;
  localparam int PIO_DIV_W   = 16;

  typedef enum logic {
    EXEC  = 1'b0,
    DELAY = 1'b1
  } sm_state_e;

endpackage

// File: rtl/pio_sm_sequencer_if.sv
// Decoder / program_counter side of the PIO sequencer.
// master : the sequencer (consumes decoder results, drives PC controls)
// slave  : the decoder/program_counter pair (or a bench standing in for them)
// Signals:
//   instr_stall/instr_jump/instr_jump_addr/instr_delay - decoder results
//   pc_en/jump_en/jump                                 - program_counter controls
//   exec_tick/delay_active/stalled                     - execution status
interface pio_sm_sequencer_if #(
  parameter int ADDR_W  = pio_pkg::PIO_ADDR_W,
  parameter int DELAY_W = pio_pkg::PIO_DELAY_W
);

  logic               instr_stall;
  logic               instr_jump;
  logic [ADDR_W-1:0]  instr_jump_addr;
  logic [DELAY_W-1:0] instr_delay;
  logic               pc_en;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump;
  logic               exec_tick;
  logic               delay_active;
  logic               stalled;

  modport master (
    input  instr_stall, instr_jump, instr_jump_addr, instr_delay,
    output pc_en, jump_en, jump, exec_tick, delay_active, stalled
  );

  modport slave (
    output instr_stall, instr_jump, instr_jump_addr, instr_delay,
    input  pc_en, jump_en, jump, exec_tick, delay_active, stalled
  );

endinterface

// File: rtl/pio_clk_div.sv
// Integer execution divider for one PIO state machine.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   en     - state machine enable; count frozen when low
//   clear  - synchronous clear of the count (restart)
//   clkdiv - divide ratio; 0 and 1 both tick on every enabled cycle
//   tick   - combinational execution tick for the current cycle
module pio_clk_div
  import pio_pkg::*;
#(
  parameter int DIV_W = PIO_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lim;

  assign div_lim = clkdiv - DIV_W'(1);

  // >= rather than == so that lowering clkdiv below the running count
  // ticks on the next enabled cycle instead of wrapping the counter.
  assign tick = en & ((clkdiv <= DIV_W'(1)) | (div_cnt >= div_lim));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pio_sm_sequencer.sv
// Execution controller for one PIO state machine. Turns divider ticks,
// decoder stall/jump/delay results and host control into the pc_en /
// jump_en / jump controls of program_counter. All outputs are combinational
// from the registered state and the current inputs.
// Ports:
//   clk, rst          - system clock, asynchronous active-low reset
//   sm_en             - enable; state and divider frozen when low
//   sm_restart        - synchronous clear of divider count and pending delay
//   clkdiv            - execution divider ratio
//   force_jump/addr   - host forced jump, highest priority
//   bus (master)      - decoder results in, program_counter controls out
module pio_sm_sequencer
  import pio_pkg::*;
#(
  parameter int ADDR_W  = PIO_ADDR_W,
  parameter int DELAY_W = PIO_DELAY_W,
  parameter int DIV_W   = PIO_DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sm_en,
  input  logic                sm_restart,
  input  logic [DIV_W-1:0]    clkdiv,
  input  logic                force_jump,
  input  logic [ADDR_W-1:0]   force_addr,
  pio_sm_sequencer_if.master  bus
);

  logic               tick;
  sm_state_e          state;
  sm_state_e          nxt_state;
  logic [DELAY_W-1:0] delay_cnt;
  logic [DELAY_W-1:0] nxt_delay_cnt;

  logic               pc_en_c;
  logic               jump_en_c;
  logic [ADDR_W-1:0]  jump_c;
  logic               exec_tick_c;
  logic               stalled_c;

  pio_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .en     (sm_en),
    .clear  (sm_restart),
    .clkdiv (clkdiv),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EXEC;
      delay_cnt <= '0;
    end else begin
      state     <= nxt_state;
      delay_cnt <= nxt_delay_cnt;
    end
  end

  // Next state and outputs
  always_comb begin
    nxt_state     = state;
    nxt_delay_cnt = delay_cnt;
    pc_en_c       = 1'b0;
    jump_en_c     = 1'b0;
    jump_c        = '0;
    exec_tick_c   = 1'b0;
    stalled_c     = 1'b0;

    if (sm_restart) begin
      nxt_state     = EXEC;
      nxt_delay_cnt = '0;
    end else if (tick) begin
      unique case (state)
        EXEC: begin
          if (bus.instr_stall) begin
            stalled_c = 1'b1;
          end else begin
            exec_tick_c = 1'b1;
            if (bus.instr_jump) begin
              jump_en_c = 1'b1;
              jump_c    = bus.instr_jump_addr;
            end else begin
              pc_en_c = 1'b1;
            end
            if (bus.instr_delay != '0) begin
              nxt_state     = DELAY;
              nxt_delay_cnt = bus.instr_delay;
            end
          end
        end
        DELAY: begin
          nxt_delay_cnt = delay_cnt - DELAY_W'(1);
          if (delay_cnt == DELAY_W'(1)) begin
            nxt_state = EXEC;
          end
        end
        default: nxt_state = EXEC;
      endcase
    end

    // Forced jump discards whatever the instruction path decided above.
    if (force_jump) begin
      pc_en_c       = 1'b0;
      jump_en_c     = 1'b1;
      jump_c        = force_addr;
      exec_tick_c   = 1'b0;
      stalled_c     = 1'b0;
      nxt_state     = EXEC;
      nxt_delay_cnt = '0;
    end

    // Outputs are combinational, so hold them low while reset is asserted.
    if (!rst) begin
      pc_en_c     = 1'b0;
      jump_en_c   = 1'b0;
      jump_c      = '0;
      exec_tick_c = 1'b0;
      stalled_c   = 1'b0;
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.jump_en      = jump_en_c;
  assign bus.jump         = jump_c;
  assign bus.exec_tick    = exec_tick_c;
  assign bus.stalled      = stalled_c;
  assign bus.delay_active = (state == DELAY);

endmodule
